// File: rtl/masked_affine_output_pipe.sv
// Three-share masked AES affine output stage: tower-basis inverse shares -> SubBytes shares.
// Optional macro AFFOUT_RESHARE_EN adds a fresh-randomness port that re-masks shares 1 and 2.
module masked_affine_output_pipe #(
  parameter int unsigned NBYTES    = 16,
  parameter logic [7:0]  AFF_CONST = 8'h63
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_s0,
  input  logic [7:0] in_s1,
  input  logic [7:0] in_s2,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_s0,
  output logic [7:0] out_s1,
  output logic [7:0] out_s2,
  output logic [3:0] out_idx,
  output logic       out_last
`ifdef AFFOUT_RESHARE_EN
  ,
  input  logic [7:0] fresh
`endif
);

  localparam logic [3:0] LAST_IDX = 4'(NBYTES - 1);

  // Undo the input-stage basis change (tower -> polynomial basis); input bit k adds column 7-k.
  function automatic logic [7:0] tower_to_aes(input logic [7:0] x);
    logic [7:0] y;
    y = 8'h00;
    if (x[7]) y = y ^ 8'h64;
    if (x[6]) y = y ^ 8'h78;
    if (x[5]) y = y ^ 8'h6E;
    if (x[4]) y = y ^ 8'h8C;
    if (x[3]) y = y ^ 8'h68;
    if (x[2]) y = y ^ 8'h29;
    if (x[1]) y = y ^ 8'hDE;
    if (x[0]) y = y ^ 8'h60;
    return y;
  endfunction

  // Linear part of the AES affine transform: b ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4.
  function automatic logic [7:0] aes_linear(input logic [7:0] b);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]};
  endfunction

  function automatic logic [7:0] lin_map(input logic [7:0] x);
    return aes_linear(tower_to_aes(x));
  endfunction

  logic       v1, v2;
  logic [7:0] r1_s0, r1_s1, r1_s2;
  logic [7:0] r2_s0, r2_s1, r2_s2;
  logic [3:0] idx1, idx2;
  logic [3:0] cnt;

  logic       adv1, adv2, in_xfer;
  logic [7:0] l_s0, l_s1, l_s2;
  logic [7:0] n2_s1, n2_s2;

  assign adv2     = !v2 || out_ready;
  assign adv1     = !v1 || adv2;
  assign in_ready = adv1;
  assign in_xfer  = in_valid && in_ready;

  // Affine logic sees only stage-1 registers, so inverter glitches never reach it.
  assign l_s0 = lin_map(r1_s0) ^ AFF_CONST;
  assign l_s1 = lin_map(r1_s1);
  assign l_s2 = lin_map(r1_s2);

`ifdef AFFOUT_RESHARE_EN
  assign n2_s1 = l_s1 ^ fresh;
  assign n2_s2 = l_s2 ^ fresh;
`else
  assign n2_s1 = l_s1;
  assign n2_s2 = l_s2;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= 4'd0;
      v1    <= 1'b0;
      v2    <= 1'b0;
      r1_s0 <= 8'h00;
      r1_s1 <= 8'h00;
      r1_s2 <= 8'h00;
      idx1  <= 4'd0;
      r2_s0 <= 8'h00;
      r2_s1 <= 8'h00;
      r2_s2 <= 8'h00;
      idx2  <= 4'd0;
    end else begin
      if (in_xfer) begin
        cnt <= (cnt == LAST_IDX) ? 4'd0 : cnt + 4'd1;
      end
      if (adv1) begin
        v1 <= in_xfer;
        if (in_xfer) begin
          r1_s0 <= in_s0;
          r1_s1 <= in_s1;
          r1_s2 <= in_s2;
          idx1  <= cnt;
        end
      end
      if (adv2) begin
        v2 <= v1;
        if (v1) begin
          r2_s0 <= l_s0;
          r2_s1 <= n2_s1;
          r2_s2 <= n2_s2;
          idx2  <= idx1;
        end
      end
    end
  end

  assign out_valid = v2;
  assign out_s0    = r2_s0;
  assign out_s1    = r2_s1;
  assign out_s2    = r2_s2;
  assign out_idx   = idx2;
  assign out_last  = (idx2 == LAST_IDX);

  stall_hold_a: assert property (@(posedge clk) disable iff (rst)
    out_valid && !out_ready |=> out_valid && $stable({out_s0, out_s1, out_s2, out_idx}));

endmodule

// File: tb/tb_masked_affine_output_pipe.sv
// Scoreboard bench for masked_affine_output_pipe; model built from the forward basis map and
// an independent GF(2^8) inverse / AES affine.
module tb_masked_affine_output_pipe;

  logic       clk = 1'b0;
  logic       rst, in_valid, in_ready, out_valid, out_ready, out_last;
  logic [7:0] in_s0, in_s1, in_s2, out_s0, out_s1, out_s2;
  logic [3:0] out_idx;
`ifdef AFFOUT_RESHARE_EN
  logic [7:0] fresh = 8'h00;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  masked_affine_output_pipe dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_s0    (in_s0),
    .in_s1    (in_s1),
    .in_s2    (in_s2),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_s0   (out_s0),
    .out_s1   (out_s1),
    .out_s2   (out_s2),
    .out_idx  (out_idx),
    .out_last (out_last)
`ifdef AFFOUT_RESHARE_EN
    ,
    .fresh    (fresh)
`endif
  );

`ifdef AFFOUT_RESHARE_EN
  initial forever begin
    @(posedge clk);
    #1 fresh = 8'($urandom);
  end
`endif

  // ---------------- reference model ----------------
  logic [7:0] a2x [8] = '{8'h98, 8'hF3, 8'hF2, 8'h48, 8'h09, 8'h81, 8'hA9, 8'hFF};
  logic [7:0] minv_t [256];
  logic [7:0] inv_t  [256];
  logic [7:0] sbox_t [256];

  function automatic logic [7:0] m_fwd(input logic [7:0] x);
    logic [7:0] y;
    y = 8'h00;
    for (int k = 0; k < 8; k++) if (x[k]) y = y ^ a2x[7-k];
    return y;
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1B) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] aff_lin(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++)
      r[i] = b[i] ^ b[(i+4)%8] ^ b[(i+5)%8] ^ b[(i+6)%8] ^ b[(i+7)%8];
    return r;
  endfunction

  function automatic logic [7:0] lmod(input logic [7:0] x);
    return aff_lin(minv_t[x]);
  endfunction

  task automatic build_tables();
    for (int y = 0; y < 256; y++) minv_t[m_fwd(8'(y))] = 8'(y);
    inv_t[0] = 8'h00;
    for (int a = 1; a < 256; a++)
      for (int b = 1; b < 256; b++)
        if (gmul(8'(a), 8'(b)) == 8'h01) inv_t[a] = 8'(b);
    for (int a = 0; a < 256; a++) sbox_t[a] = aff_lin(inv_t[a]) ^ 8'h63;
  endtask

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [7:0] e0, e1, e2;
    logic [3:0] idx;
  } exp_t;

  exp_t        sbq[$];
  exp_t        e_m;
  int          mcnt = 0;
  logic [28:0] got_v, want_v;

  always @(negedge clk) begin
    if (rst) begin
      sbq.delete();
      mcnt = 0;
    end else begin
      if (out_valid && out_ready) begin
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL sb_extra: unexpected output idx=%0d s=%h/%h/%h, required none",
                   out_idx, out_s0, out_s1, out_s2);
        end else begin
          e_m = sbq.pop_front();
`ifdef AFFOUT_RESHARE_EN
          got_v  = {out_s0, out_s1 ^ out_s2, 8'h00, out_idx, out_last};
          want_v = {e_m.e0, e_m.e1 ^ e_m.e2, 8'h00, e_m.idx, e_m.idx == 4'd15};
`else
          got_v  = {out_s0, out_s1, out_s2, out_idx, out_last};
          want_v = {e_m.e0, e_m.e1, e_m.e2, e_m.idx, e_m.idx == 4'd15};
`endif
          if (got_v !== want_v) begin
            errors++;
            $display("FAIL sb_output: got %h, required %h", got_v, want_v);
          end
        end
      end
      if (in_valid && in_ready) begin
        sbq.push_back('{e0: lmod(in_s0) ^ 8'h63, e1: lmod(in_s1), e2: lmod(in_s2),
                        idx: 4'(mcnt)});
        mcnt = (mcnt == 15) ? 0 : mcnt + 1;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    in_valid = 1'b1; in_s0 = a; in_s1 = b; in_s2 = c;
  endtask

  task automatic drive_rand();
    drive(8'($urandom), 8'($urandom), 8'($urandom));
  endtask

  task automatic drain(input int n);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b, required 0", out_valid); end
    checks++; if ({out_s0, out_s1, out_s2} !== 24'h0) begin errors++; $display("FAIL rst_shares: got %h%h%h, required 000000", out_s0, out_s1, out_s2); end
    checks++; if (out_idx !== 4'd0) begin errors++; $display("FAIL rst_idx: got %0d, required 0", out_idx); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL rst_last: got %b, required 0", out_last); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b, required 1", in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_vectors();
    int got;
    out_ready = 1'b1;
    drive(8'h00, 8'h00, 8'h00);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lat_early: out_valid got %b, required 0", out_valid); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL lat_2cyc: out_valid got %b, required 1", out_valid); end
    checks++; if (out_s0 !== 8'h63) begin errors++; $display("FAIL zero_s0: got %h, required 63", out_s0); end
`ifdef AFFOUT_RESHARE_EN
    checks++; if (out_s1 !== out_s2) begin errors++; $display("FAIL zero_s12: got %h/%h, required equal", out_s1, out_s2); end
`else
    checks++; if ({out_s1, out_s2} !== 16'h0) begin errors++; $display("FAIL zero_s12: got %h/%h, required 00/00", out_s1, out_s2); end
`endif
    checks++; if (out_idx !== 4'd0) begin errors++; $display("FAIL zero_idx: got %0d, required 0", out_idx); end
    @(posedge clk); #1;
    drive(8'hFF, 8'h00, 8'h00);
    @(posedge clk); #1 drive(8'h5A, 8'hA5, 8'h00);
    @(posedge clk); #1 in_valid = 1'b0;
    got = 0;
    for (int c = 0; c < 8 && got < 2; c++) begin
      @(negedge clk);
      if (out_valid) begin
        checks++;
        if ((out_s0 ^ out_s1 ^ out_s2) !== 8'h7C) begin
          errors++; $display("FAIL vec_xor%0d: got %h, required 7c", got, out_s0 ^ out_s1 ^ out_s2);
        end
        got++;
      end
      @(posedge clk); #1;
    end
    checks++; if (got != 2) begin errors++; $display("FAIL vec_count: got %0d, required 2", got); end
  endtask

  task automatic test_sbox();
    logic [7:0] refq[$];
    logic [7:0] r1, r2, x, rv;
    int sent, recv, budget;
    bit acc;
    do_reset();
    sent = 0; recv = 0; budget = 0;
    x = m_fwd(inv_t[0]); r1 = 8'($urandom); r2 = 8'($urandom);
    drive(x ^ r1 ^ r2, r1, r2);
    while (recv < 256 && budget < 3000) begin
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = in_valid && in_ready;
      if (acc) begin refq.push_back(sbox_t[sent]); sent++; end
      if (out_valid && out_ready) begin
        checks++;
        rv = (refq.size() > 0) ? refq.pop_front() : 8'hxx;
        if ((out_s0 ^ out_s1 ^ out_s2) !== rv) begin
          errors++; $display("FAIL sbox[%0d]: got %h, required %h", recv, out_s0 ^ out_s1 ^ out_s2, rv);
        end
        recv++;
      end
      @(posedge clk); #1;
      if (acc) begin
        if (sent < 256) begin
          x = m_fwd(inv_t[sent]); r1 = 8'($urandom); r2 = 8'($urandom);
          drive(x ^ r1 ^ r2, r1, r2);
        end else in_valid = 1'b0;
      end
      budget++;
    end
    checks++; if (recv != 256) begin errors++; $display("FAIL sbox_count: got %0d, required 256", recv); end
    drain(3);
  endtask

  task automatic test_stream20();
    int first, lastc, nout, nlast, lastpos;
    do_reset();
    first = -1; lastc = -1; nout = 0; nlast = 0; lastpos = -1;
    for (int c = 0; c < 30; c++) begin
      if (c < 20) drive_rand(); else in_valid = 1'b0;
      @(negedge clk);
      if (out_valid) begin
        if (first < 0) first = c;
        lastc = c; nout++;
        if (out_last) begin nlast++; lastpos = nout; end
      end
      @(posedge clk); #1;
    end
    checks++; if (nout != 20) begin errors++; $display("FAIL s20_count: got %0d, required 20", nout); end
    checks++; if (lastc - first != 19) begin errors++; $display("FAIL s20_rate: span got %0d, required 19", lastc - first); end
    checks++; if (nlast != 1 || lastpos != 16) begin errors++; $display("FAIL s20_last: got %0d at output %0d, required 1 at 16", nlast, lastpos); end
  endtask

  task automatic test_stall();
    int acc_n, sent, budget;
    bit nw, have;
    logic [23:0] snap_s;
    logic [3:0]  snap_i;
    do_reset();
    for (int k = 0; k < 4; k++) begin drive_rand(); @(posedge clk); #1; end
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 out_ready = 1'b0;
    acc_n = 0; have = 1'b0;
    drive_rand();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      nw = in_valid && in_ready;
      if (nw) acc_n++;
      if (out_valid) begin
        if (!have) begin
          have = 1'b1; snap_s = {out_s0, out_s1, out_s2}; snap_i = out_idx;
        end else begin
          checks++;
          if ({out_s0, out_s1, out_s2, out_idx} !== {snap_s, snap_i}) begin
            errors++; $display("FAIL stall_frozen: got %h%h%h/%0d, required %h/%0d",
                               out_s0, out_s1, out_s2, out_idx, snap_s, snap_i);
          end
        end
      end
      @(posedge clk); #1;
      if (nw) drive_rand();
    end
    @(negedge clk);
    checks++; if (acc_n != 2) begin errors++; $display("FAIL stall_accepts: got %0d, required 2", acc_n); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready: got %b, required 0", in_ready); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid: got %b, required 1", out_valid); end
    @(posedge clk); #1;
    out_ready = 1'b1; sent = 0; budget = 0;
    while (sent < 4 && budget < 20) begin
      @(negedge clk);
      nw = in_valid && in_ready;
      if (nw) sent++;
      @(posedge clk); #1;
      if (nw) begin if (sent < 4) drive_rand(); else in_valid = 1'b0; end
      budget++;
    end
    drain(4);
    checks++; if (sent != 4) begin errors++; $display("FAIL stall_resume: sent %0d, required 4", sent); end
    checks++; if (sbq.size() != 0) begin errors++; $display("FAIL stall_lost: %0d pending, required 0", sbq.size()); end
  endtask

  task automatic test_midreset();
    int acc_n;
    bit nw, seen;
    do_reset();
    out_ready = 1'b0; acc_n = 0;
    drive_rand();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      nw = in_valid && in_ready;
      if (nw) acc_n++;
      @(posedge clk); #1;
      if (nw) drive_rand();
    end
    @(negedge clk);
    checks++; if (!(in_ready === 1'b0 && out_valid === 1'b1 && acc_n == 2)) begin
      errors++; $display("FAIL mr_full: in_ready=%b out_valid=%b acc=%0d, required 0/1/2", in_ready, out_valid, acc_n);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mr_valid: got %b, required 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mr_in_ready: got %b, required 1", in_ready); end
    @(posedge clk); #1;
    out_ready = 1'b1;
    drive_rand();
    @(posedge clk); #1 in_valid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 6 && !seen; c++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        checks++; if (out_idx !== 4'd0) begin errors++; $display("FAIL mr_idx: got %0d, required 0", out_idx); end
      end
      @(posedge clk); #1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL mr_timeout: got no output, required one"); end
    drain(3);
    checks++; if (sbq.size() != 0) begin errors++; $display("FAIL mr_pending: %0d pending, required 0", sbq.size()); end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_s0 = 8'h00; in_s1 = 8'h00; in_s2 = 8'h00;
    build_tables();
    test_reset();
    test_vectors();
    test_sbox();
    test_stream20();
    test_stall();
    test_midreset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
